// File: rtl/pic_uart_tx_pkg.sv
// Shared definitions for the picture readback UART transmitter:
// FSM encoding, default clocking/baud figures and picture RAM geometry.
package pic_uart_tx_pkg;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned UART_BPS_DEF = 9600;
  localparam int unsigned PIC_SIZE_DEF = 10000;
  localparam int unsigned ADDR_W       = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// Serialises one byte as start bit, 8 data bits LSB first, stop bit,
// each held BAUD_CNT_MAX clocks; tx is registered and idles high.
module uart_tx_byte #(
  parameter int unsigned BAUD_CNT_MAX = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       byte_done
);

  localparam int unsigned CW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT_MAX - 1);

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic          baud_wrap;

  assign baud_wrap = active && (baud_cnt == BAUD_LAST);
  assign byte_done = baud_wrap && (bit_cnt == 4'd9);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else if (load) begin
      // start bit goes out on the cycle right after the load
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= data;
      tx       <= 1'b0;
    end else if (active) begin
      if (baud_wrap) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          bit_cnt <= '0;
          active  <= 1'b0;
          tx      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd8) begin
            tx <= 1'b1;
          end else begin
            tx    <= shift[0];
            shift <= {1'b0, shift[7:1]};
          end
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_uart_tx.sv
// Reads a picture out of RAM byte by byte on a start pulse and sends each
// byte over the UART; done pulses during the final stop-bit cycle.
module pic_uart_tx
  import pic_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned UART_BPS = UART_BPS_DEF,
  parameter int unsigned PIC_SIZE = PIC_SIZE_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [7:0]        rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_SIZE - 1);

  state_t state, state_nxt;
  logic   load;
  logic   byte_done;
  logic   last_byte;

  assign last_byte = (rd_addr == LAST_ADDR);

  uart_tx_byte #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_tx_byte (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (load),
    .data     (rd_data),
    .tx       (tx),
    .byte_done(byte_done)
  );

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    load      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = READ;
      READ: begin
        rd_en     = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: begin
        load      = 1'b1;
        state_nxt = SEND;
      end
      SEND: begin
        if (byte_done) begin
          if (last_byte) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      rd_addr <= '0;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        rd_addr <= '0;
        busy    <= 1'b1;
      end else if (state == SEND && byte_done) begin
        if (last_byte) busy    <= 1'b0;
        else           rd_addr <= rd_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pic_uart_tx.sv
// Directed bench for pic_uart_tx: 4-byte picture, 5-clock bit period,
// every output compared each cycle against a hand-derived frame schedule.
module tb_pic_uart_tx;

  localparam int unsigned BAUD  = 5;
  localparam int unsigned BYTE_T = 2 + 10 * BAUD;
  localparam int unsigned NBYTE = 4;
  localparam int unsigned FRAME_T = NBYTE * BYTE_T;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        start;
  logic [7:0]  rd_data;
  logic        rd_en;
  logic [13:0] rd_addr;
  logic        tx;
  logic        busy;
  logic        done;

  logic [7:0]  mem [0:3];
  int          vectors;
  int          miscompares;
  int          done_cnt;

  pic_uart_tx #(
    .CLK_FREQ(50_000),
    .UART_BPS(9600),
    .PIC_SIZE(4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .rd_data  (rd_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (rd_en) rd_data <= mem[rd_addr[1:0]];
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {tx, rd_en, busy, done, rd_addr}
  function automatic logic [17:0] observed();
    return {tx, rd_en, busy, done, rd_addr};
  endfunction

  function automatic logic [17:0] expected(input int unsigned t);
    int unsigned k, off, b;
    logic [7:0] d;
    logic       etx;
    k   = t / BYTE_T;
    off = t % BYTE_T;
    d   = mem[k];
    if (off < 2) etx = 1'b1;
    else begin
      b = (off - 2) / BAUD;
      if (b == 0)      etx = 1'b0;
      else if (b == 9) etx = 1'b1;
      else             etx = d[b-1];
    end
    return {etx, (off == 0), 1'b1, (t == FRAME_T - 1), 14'(k)};
  endfunction

  // mode 0: plain frame; 1: extra starts at t=30 and in the done cycle;
  // 2: reset asserted during data bit 3 of byte 1
  task automatic run_frame(input int mode);
    done_cnt = 0;
    for (int unsigned t = 0; t < FRAME_T; t++) begin
      start = (mode == 1) && (t == 30 || t == FRAME_T - 1);
      check($sformatf("frame%0d_t%0d", mode, t), observed(), expected(t));
      if (mode == 2 && t == 74) begin
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("abort_outputs", observed(), {1'b1, 1'b0, 1'b0, 1'b0, 14'd0});
        @(negedge sys_clk);
        check("abort_no_done", 18'(done_cnt), 18'd0);
        return;
      end
      @(negedge sys_clk);
    end
    start = 1'b0;
    check($sformatf("frame%0d_idle", mode), observed(), {1'b1, 1'b0, 1'b0, 1'b0, 14'd3});
    check($sformatf("frame%0d_done_cnt", mode), 18'(done_cnt), 18'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    sys_rst_n   = 1'b0;
    start       = 1'b0;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;

    repeat (3) @(negedge sys_clk);
    check("reset_state", observed(), {1'b1, 1'b0, 1'b0, 1'b0, 14'd0});
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("idle_state", observed(), {1'b1, 1'b0, 1'b0, 1'b0, 14'd0});

    // frame A5,3C,00,FF
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    run_frame(0);

    // 0x55 pattern with ignored starts, then a start right after done
    mem[0] = 8'h55; mem[1] = 8'h55; mem[2] = 8'h55; mem[3] = 8'h55;
    repeat (3) @(negedge sys_clk);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    run_frame(1);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    run_frame(2);

    // start on the first cycle after reset release resends from address 0
    mem[0] = 8'h81; mem[1] = 8'h7E; mem[2] = 8'hC3; mem[3] = 8'h12;
    sys_rst_n = 1'b1;
    start     = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    run_frame(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
